// File: rtl/atconv_seq.sv
// Atrous-conv sequencer: dilated 3x3 tap walk, layer-0 writes, 2x2 max-pool pass.
// Define ATCONV_SEQ_POOL_EN to build the layer-1 pool pass.
module atconv_seq #(
  parameter int IMG_W = 64,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  output logic [3:0]    k_idx,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          pool_clr,
  output logic          pool_en,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic          csel
);

  localparam int HW = AW / 2;
  localparam logic [HW-1:0] EDGE = HW'(IMG_W - 1);

`ifdef ATCONV_SEQ_POOL_EN
  typedef enum logic [2:0] {IDLE, L0_RD, L0_WR, L1_RD, L1_WR} state_t;
`else
  typedef enum logic [1:0] {IDLE, L0_RD, L0_WR} state_t;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [3:0]    k_q, k_d;
  logic [3:0]    off;

  logic          busy_q, busy_d;
  logic [AW-1:0] iaddr_q, iaddr_d;
  logic [3:0]    k_idx_q, k_idx_d;
  logic          mac_clr_q, mac_clr_d;
  logic          mac_en_q, mac_en_d;
  logic          cwr_q, cwr_d;
  logic [AW-1:0] caddr_wr_q, caddr_wr_d;
`ifdef ATCONV_SEQ_POOL_EN
  logic [1:0]    j_q, j_d;
  logic          pool_clr_q, pool_clr_d;
  logic          pool_en_q, pool_en_d;
  logic          crd_q, crd_d;
  logic [AW-1:0] caddr_rd_q, caddr_rd_d;
  logic          csel_q, csel_d;
`endif

  // Replicate padding: offset code 0 = -2, 1 = 0, 2 = +2
  function automatic logic [HW-1:0] tap(
    input logic [HW-1:0] p,
    input logic [1:0]    o
  );
    case (o)
      2'd0:    tap = (p < HW'(2)) ? '0 : p - HW'(2);
      2'd2:    tap = (p > EDGE - HW'(2)) ? EDGE : p + HW'(2);
      default: tap = p;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    k_d     = k_q;
`ifdef ATCONV_SEQ_POOL_EN
    j_d     = j_q;
`endif
    case (state_q)
      IDLE: begin
        if (ready) begin
          state_d = L0_RD;
          pix_d   = '0;
          k_d     = '0;
        end
      end
      L0_RD: begin
        if (k_q == 4'd8) state_d = L0_WR;
        else             k_d = k_q + 4'd1;
      end
      L0_WR: begin
        k_d = '0;
        if (pix_q == '1) begin
`ifdef ATCONV_SEQ_POOL_EN
          state_d = L1_RD;
          pix_d   = '0;
          j_d     = '0;
`else
          state_d = IDLE;
`endif
        end else begin
          state_d = L0_RD;
          pix_d   = pix_q + 1'b1;
        end
      end
`ifdef ATCONV_SEQ_POOL_EN
      L1_RD: begin
        if (j_q == 2'd3) state_d = L1_WR;
        else             j_d = j_q + 2'd1;
      end
      L1_WR: begin
        j_d = '0;
        if (pix_q[AW-3:0] == '1) begin
          state_d = IDLE;
        end else begin
          state_d = L1_RD;
          pix_d   = pix_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (k_d)
      4'd0:    off = 4'b0000;
      4'd1:    off = 4'b0001;
      4'd2:    off = 4'b0010;
      4'd3:    off = 4'b0100;
      4'd4:    off = 4'b0101;
      4'd5:    off = 4'b0110;
      4'd6:    off = 4'b1000;
      4'd7:    off = 4'b1001;
      4'd8:    off = 4'b1010;
      default: off = 4'b0101;
    endcase
  end

  // Outputs are decoded from the next state so they register with it
  always_comb begin
    busy_d     = (state_d != IDLE);
    iaddr_d    = '0;
    k_idx_d    = '0;
    mac_clr_d  = 1'b0;
    mac_en_d   = 1'b0;
    cwr_d      = 1'b0;
    caddr_wr_d = '0;
`ifdef ATCONV_SEQ_POOL_EN
    pool_clr_d = 1'b0;
    pool_en_d  = 1'b0;
    crd_d      = 1'b0;
    caddr_rd_d = '0;
    csel_d     = 1'b0;
`endif
    case (state_d)
      L0_RD: begin
        iaddr_d   = {tap(pix_d[AW-1:HW], off[3:2]),
                     tap(pix_d[HW-1:0], off[1:0])};
        k_idx_d   = k_d;
        mac_en_d  = 1'b1;
        mac_clr_d = (k_d == 4'd0);
      end
      L0_WR: begin
        cwr_d      = 1'b1;
        caddr_wr_d = pix_d;
      end
`ifdef ATCONV_SEQ_POOL_EN
      L1_RD: begin
        crd_d      = 1'b1;
        pool_en_d  = 1'b1;
        pool_clr_d = (j_d == 2'd0);
        caddr_rd_d = {pix_d[AW-3:HW-1], j_d[1],
                      pix_d[HW-2:0], j_d[0]};
      end
      L1_WR: begin
        cwr_d      = 1'b1;
        csel_d     = 1'b1;
        caddr_wr_d = {2'b00, pix_d[AW-3:0]};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pix_q      <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      iaddr_q    <= '0;
      k_idx_q    <= '0;
      mac_clr_q  <= 1'b0;
      mac_en_q   <= 1'b0;
      cwr_q      <= 1'b0;
      caddr_wr_q <= '0;
`ifdef ATCONV_SEQ_POOL_EN
      j_q        <= '0;
      pool_clr_q <= 1'b0;
      pool_en_q  <= 1'b0;
      crd_q      <= 1'b0;
      caddr_rd_q <= '0;
      csel_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      iaddr_q    <= iaddr_d;
      k_idx_q    <= k_idx_d;
      mac_clr_q  <= mac_clr_d;
      mac_en_q   <= mac_en_d;
      cwr_q      <= cwr_d;
      caddr_wr_q <= caddr_wr_d;
`ifdef ATCONV_SEQ_POOL_EN
      j_q        <= j_d;
      pool_clr_q <= pool_clr_d;
      pool_en_q  <= pool_en_d;
      crd_q      <= crd_d;
      caddr_rd_q <= caddr_rd_d;
      csel_q     <= csel_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign iaddr    = iaddr_q;
  assign k_idx    = k_idx_q;
  assign mac_clr  = mac_clr_q;
  assign mac_en   = mac_en_q;
  assign cwr      = cwr_q;
  assign caddr_wr = caddr_wr_q;
`ifdef ATCONV_SEQ_POOL_EN
  assign pool_clr = pool_clr_q;
  assign pool_en  = pool_en_q;
  assign crd      = crd_q;
  assign caddr_rd = caddr_rd_q;
  assign csel     = csel_q;
`else
  assign pool_clr = 1'b0;
  assign pool_en  = 1'b0;
  assign crd      = 1'b0;
  assign caddr_rd = '0;
  assign csel     = 1'b0;
`endif

endmodule

// File: tb/tb_atconv_seq.sv
// Scoreboard bench for atconv_seq: expected event stream queued by stimulus,
// monitor pops on every read/write strobe; directed hand vectors at key pixels.
module tb_atconv_seq;

  localparam int AW = 12;
`ifdef ATCONV_SEQ_POOL_EN
  localparam int EXP_W  = 46080;
  localparam int EXP_L1 = 1024;
`else
  localparam int EXP_W  = 40960;
  localparam int EXP_L1 = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [3:0]    k_idx;
  logic          mac_clr;
  logic          mac_en;
  logic          pool_clr;
  logic          pool_en;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic          csel;

  atconv_seq dut (
    .clk(clk), .reset(reset), .ready(ready),
    .busy(busy), .iaddr(iaddr), .k_idx(k_idx),
    .mac_clr(mac_clr), .mac_en(mac_en),
    .pool_clr(pool_clr), .pool_en(pool_en),
    .crd(crd), .caddr_rd(caddr_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .csel(csel)
  );

  initial forever #5 clk = ~clk;

  // kind: 0 image read, 1 pool read, 2 write; flag: clr or csel
  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] addr;
    logic        flag;
    logic [3:0]  k;
  } ev_t;

  ev_t exp_q[$];
  int  vecs = 0;
  int  miss = 0;
  int  ev_idx = 0;
  int  wr0 = 0, wr1 = 0;
  int  width = 0, gap = 0;
  int  widths_seen = 0;
  bit  seen_fall = 0, chk_fall = 0, prev_busy = 0;

  int tbl0[10] = '{0, 0, 2, 0, 0, 2, 128, 128, 130, 0};
  int tbli[9]  = '{520, 522, 524, 648, 650, 652, 776, 778, 780};
  int tbll[10] = '{3965, 3967, 3967, 4093, 4095, 4095,
                   4093, 4095, 4095, 4095};
  int tblp0[5] = '{0, 1, 64, 65, 0};
  int tblp1[5] = '{4030, 4031, 4094, 4095, 1023};

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    vecs++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_run();
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        for (int k = 0; k < 9; k++) begin
          int rr, cc;
          rr = r + (k / 3) * 2 - 2;
          cc = c + (k % 3) * 2 - 2;
          if (rr < 0) rr = 0;
          if (rr > 63) rr = 63;
          if (cc < 0) cc = 0;
          if (cc > 63) cc = 63;
          exp_q.push_back('{2'd0, 12'(rr * 64 + cc), (k == 0), 4'(k)});
        end
        exp_q.push_back('{2'd2, 12'(r * 64 + c), 1'b0, 4'd0});
      end
    end
`ifdef ATCONV_SEQ_POOL_EN
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        for (int j = 0; j < 4; j++)
          exp_q.push_back('{2'd1, 12'((2 * r + j / 2) * 64 + 2 * c + j % 2),
                            (j == 0), 4'd0});
        exp_q.push_back('{2'd2, 12'(r * 32 + c), 1'b1, 4'd0});
      end
    end
`endif
  endtask

  always @(negedge clk) begin
    ev_t got, e;
    int  n, i;
    if (!reset) begin
      prev_busy = 0;
      seen_fall = 0;
      chk_fall  = 0;
      ev_idx    = 0;
      width     = 0;
    end else begin
      if (chk_fall) begin
        check("busy_fall", 64'(busy), 64'(0));
        chk_fall = 0;
      end
      if (busy && !prev_busy) begin
        if (seen_fall) check("idle_gap", 64'(gap), 64'(1));
        ev_idx = 0; wr0 = 0; wr1 = 0; width = 0; seen_fall = 0;
      end
      if (!busy && prev_busy) begin
        check("busy_width", 64'(width), 64'(EXP_W));
        check("l0_writes", 64'(wr0), 64'(4096));
        check("l1_writes", 64'(wr1), 64'(EXP_L1));
        widths_seen++;
        seen_fall = 1;
        gap = 0;
      end
      if (busy) width++;
      else if (seen_fall) gap++;
      prev_busy = busy;

      n = int'(mac_en) + int'(crd) + int'(cwr);
      if (n > 1) check("strobe_excl", 64'(n), 64'(1));
      if (n == 1) begin
        if (mac_en)   got = '{2'd0, iaddr, mac_clr, k_idx};
        else if (crd) got = '{2'd1, caddr_rd, pool_clr, 4'd0};
        else          got = '{2'd2, caddr_wr, csel, 4'd0};
        if (exp_q.size() == 0) begin
          check("sb_empty", 64'(got), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_event", 64'(got), 64'(e));
        end
        i = ev_idx;
        if (i < 10) check("px0_seq", 64'(got.addr), 64'(tbl0[i]));
        if (i == 0) check("px0_clr", 64'(got.flag), 64'(1));
        if (i >= 6500 && i < 6509)
          check("px650_seq", 64'(got.addr), 64'(tbli[i - 6500]));
        if (i >= 40950 && i < 40960)
          check("px4095_seq", 64'(got.addr), 64'(tbll[i - 40950]));
        if (i >= 40960 && i < 40965)
          check("pool0_seq", 64'(got.addr), 64'(tblp0[i - 40960]));
        if (i == 40964) check("pool0_csel", 64'(got.flag), 64'(1));
        if (i >= 46075 && i < 46080)
          check("pool1023_seq", 64'(got.addr), 64'(tblp1[i - 46075]));
        if (got.kind == 2'd2) begin
          if (got.flag) wr1++;
          else          wr0++;
        end
        if (i == EXP_W - 1) chk_fall = 1;
        ev_idx++;
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {busy, iaddr, k_idx, mac_clr, mac_en, pool_clr, pool_en,
                 crd, caddr_rd, cwr, caddr_wr, csel}, 64'(0));
  endtask

  initial begin
    int cyc;
    reset = 1'b0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_state");
    push_run();
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("start_busy", 64'(busy), 64'(1));
    check("start_iaddr", 64'(iaddr), 64'(0));
    check("start_clr", 64'(mac_clr), 64'(1));
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      #2 ready = 1'($urandom_range(0, 1));
    end
    cyc = 0;
    while (ev_idx < 1000 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    if (ev_idx < 1000) check("reach_px100", 64'(ev_idx), 64'(1000));
    #2 reset = 1'b0;
    #1 check_all_zero("midrun_reset");
    exp_q.delete();
    push_run();
    ready = 1'b1;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    check("restart_busy", 64'(busy), 64'(1));
    check("restart_iaddr", 64'(iaddr), 64'(0));
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #2 ready = 1'($urandom_range(0, 1));
    end
    ready = 1'b1;
    push_run();
    cyc = 0;
    while (widths_seen < 1 && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    if (widths_seen < 1) check("run_done", 64'(widths_seen), 64'(1));
    cyc = 0;
    while (!(busy && ev_idx >= 20) && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    check("rerun_started", 64'(busy && ev_idx >= 20), 64'(1));
    check("width_count", 64'(widths_seen), 64'(1));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
